// File: rtl/prog_fetch_seq.sv
// Fetch sequencer for the picoMIPS program ROM: owns the PC and presents one registered instruction
// over a valid/ready handshake. Optional retired-instruction counter behind PROG_FETCH_RETCOUNT_EN.
module prog_fetch_seq #(
    parameter int Psize      = 4,
    parameter int Isize      = 17,
    parameter int RESET_ADDR = 0
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic             halt_req,
    output logic [Psize-1:0] address,
    input  logic [Isize-1:0] I_mem,
    output logic [Isize-1:0] instr,
    output logic [Psize-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             branch_en,
    input  logic             branch_rel,
    input  logic [Psize-1:0] branch_off,
    output logic             busy
`ifdef PROG_FETCH_RETCOUNT_EN
    ,
    output logic [15:0]      ret_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [Psize-1:0] L_RESET_PC = RESET_ADDR[Psize-1:0];
    localparam logic [Psize-1:0] L_PC_ONE   = {{(Psize-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [Psize-1:0] r_pc;
    logic [Psize-1:0] r_instr_pc;
    logic [Isize-1:0] r_instr;
    logic             r_instr_valid;
    logic             r_busy;

    logic             w_consume;
    logic             w_redirect;
    logic [Psize-1:0] w_target;

    assign w_consume  = r_instr_valid & instr_ready;
    assign w_redirect = w_consume & branch_en;
    // Relative targets are based on the address of the word being consumed, not the run-ahead pc.
    assign w_target   = branch_rel ? (r_instr_pc + branch_off) : branch_off;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state       <= ST_IDLE;
            r_pc          <= L_RESET_PC;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_pc    <= L_RESET_PC;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_redirect) begin
                        r_pc          <= w_target;
                        r_instr_valid <= 1'b0;
                    end else if (!r_instr_valid || w_consume) begin
                        r_instr       <= I_mem;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_pc          <= r_pc + L_PC_ONE;
                    end
                    if (halt_req) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (!r_instr_valid || w_consume) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= ST_HALT;
                        r_busy        <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Resume from the held pc: the drained word was already consumed.
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_instr_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

`ifdef PROG_FETCH_RETCOUNT_EN
    logic [15:0] r_ret_count;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_ret_count <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_ret_count <= '0;
        end else if (w_consume && (r_ret_count != 16'hFFFF)) begin
            r_ret_count <= r_ret_count + 16'd1;
        end
    end

    assign ret_count = r_ret_count;
`endif

    assign address     = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;

endmodule

// File: tb/tb_prog_fetch_seq.sv
// Bench for prog_fetch_seq: directed vector table for the fetch/branch/halt corners, then random
// traffic checked against a program-order transaction model.
module tb_prog_fetch_seq;

    logic        clk;
    logic        nReset;
    logic        start;
    logic        halt_req;
    logic [3:0]  address;
    logic [16:0] I_mem;
    logic [16:0] instr;
    logic [3:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_en;
    logic        branch_rel;
    logic [3:0]  branch_off;
    logic        busy;
`ifdef PROG_FETCH_RETCOUNT_EN
    logic [15:0] ret_count;
`endif

    logic [16:0] rom [16];
    assign I_mem = rom[address];

    int tests;
    int fails;

    prog_fetch_seq #(.Psize(4), .Isize(17), .RESET_ADDR(0)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .start       (start),
        .halt_req    (halt_req),
        .address     (address),
        .I_mem       (I_mem),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch_en   (branch_en),
        .branch_rel  (branch_rel),
        .branch_off  (branch_off),
        .busy        (busy)
`ifdef PROG_FETCH_RETCOUNT_EN
        ,
        .ret_count   (ret_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       halt;
        logic       rdy;
        logic       ben;
        logic       brel;
        logic [3:0] boff;
        logic       ev;
        logic [3:0] eipc;
        logic       ebusy;
        logic [3:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic st, input logic hl, input logic rd, input logic be,
                                input logic br, input logic [3:0] bo, input logic ev,
                                input logic [3:0] eipc, input logic eb, input logic [3:0] ea);
        vec_t v;
        v.start = st; v.halt = hl; v.rdy = rd; v.ben = be; v.brel = br; v.boff = bo;
        v.ev = ev; v.eipc = eipc; v.ebusy = eb; v.eaddr = ea;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic st, input logic hl, input logic rd, input logic be,
                         input logic br, input logic [3:0] bo);
        start = st; halt_req = hl; instr_ready = rd; branch_en = be; branch_rel = br; branch_off = bo;
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        drive(0, 0, 0, 0, 0, 4'd0);
        repeat (2) @(posedge clk);
        #3 nReset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        v;
        logic [3:0]  exp_pc;
        logic [16:0] prev_instr;
        logic [3:0]  prev_ipc;
        logic        prev_stall, prev_redir, cons, found;
        logic        r_st, r_hl, r_rd, r_be, r_br;
        logic [3:0]  r_bo;
        int          ncons;
        int          model_cnt;

        tests = 0;
        fails = 0;
        for (int k = 0; k < 16; k++) rom[k] = 17'(k + 100);

        // Directed table: outputs expected in a cycle, with the inputs driven in that cycle.
        add(1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
        add(0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd0);
        for (int k = 0; k < 16; k++) add(0, 0, 1, 0, 0, 4'd0, 1, 4'(k), 1, 4'(k + 1));
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd0, 1, 4'd1);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd1, 1, 4'd2);
        for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 4'd0, 1, 4'd2, 1, 4'd3);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd2, 1, 4'd3);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd3, 1, 4'd4);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd4, 1, 4'd5);
        add(0, 0, 1, 1, 0, 4'd12, 1, 4'd5, 1, 4'd6);
        add(0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd12);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd12, 1, 4'd13);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd13, 1, 4'd14);
        add(0, 0, 1, 1, 1, 4'd3, 1, 4'd14, 1, 4'd15);
        add(0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd1);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd1, 1, 4'd2);
        add(0, 1, 0, 0, 0, 4'd0, 1, 4'd2, 1, 4'd3);
        add(0, 0, 0, 0, 0, 4'd0, 1, 4'd2, 1, 4'd3);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd2, 1, 4'd3);
        add(1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 4'd3);
        add(0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 4'd3);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd3, 1, 4'd4);
        add(0, 0, 1, 0, 0, 4'd0, 1, 4'd4, 1, 4'd5);

        nReset = 1'b1;
        drive(0, 0, 0, 0, 0, 4'd0);
        #2 nReset = 1'b0;
        #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", address, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            chk($sformatf("v%0d_valid", i), instr_valid, v.ev);
            chk($sformatf("v%0d_busy", i), busy, v.ebusy);
            chk($sformatf("v%0d_addr", i), address, v.eaddr);
            if (v.ev) begin
                chk($sformatf("v%0d_instr_pc", i), instr_pc, v.eipc);
                chk($sformatf("v%0d_instr", i), instr, 32'(v.eipc) + 100);
            end
            $display("[TB] vec %0d valid=%0d pc=%0d instr=%0d busy=%0d addr=%0d",
                     i, instr_valid, instr_pc, instr, busy, address);
            drive(v.start, v.halt, v.rdy, v.ben, v.brel, v.boff);
            @(posedge clk);
            #1;
        end

        // Run on to instr_pc=9, then reset asynchronously between clock edges.
        drive(0, 0, 1, 0, 0, 4'd0);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (instr_valid && instr_pc == 4'd9) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("reach_pc9", found, 1);
        #2 nReset = 1'b0;
        #1;
        chk("async_valid", instr_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_addr", address, 0);
`ifdef PROG_FETCH_RETCOUNT_EN
        chk("async_retcnt", ret_count, 0);
`endif
        #3 nReset = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 0, 1, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("restart_lat1", instr_valid, 0);
        @(posedge clk);
        #1;
        chk("restart_valid", instr_valid, 1);
        chk("restart_pc", instr_pc, 0);
        repeat (10) @(posedge clk);
        #1;
        instr_ready = 1'b0;
        chk("ten_consumes_pc", instr_pc, 10);
`ifdef PROG_FETCH_RETCOUNT_EN
        chk("ret_count10", ret_count, 10);
`endif

        // Random traffic: consumed words must follow program order with branch redirects.
        for (int k = 0; k < 16; k++) rom[k] = 17'($urandom);
        do_reset();
        drive(1, 0, 0, 0, 0, 4'd0);
        @(posedge clk);
        #1;
        exp_pc = 4'd0;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        prev_instr = '0;
        prev_ipc = '0;
        ncons = 0;
        model_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_stall) begin
                chk("rnd_stall_valid", instr_valid, 1);
                chk("rnd_stall_instr", instr, prev_instr);
                chk("rnd_stall_pc", instr_pc, prev_ipc);
            end
            if (prev_redir) chk("rnd_bubble", instr_valid, 0);
            if (!busy) chk("rnd_idle_valid", instr_valid, 0);
`ifdef PROG_FETCH_RETCOUNT_EN
            chk("rnd_retcnt", ret_count, model_cnt);
`endif
            r_st = ($urandom_range(0, 9) == 0);
            r_hl = ($urandom_range(0, 32) == 0);
            r_rd = ($urandom_range(0, 3) != 0);
            r_be = ($urandom_range(0, 4) == 0);
            r_br = 1'($urandom);
            r_bo = 4'($urandom);
            drive(r_st, r_hl, r_rd, r_be, r_br, r_bo);
            cons = instr_valid & r_rd;
            if (cons) begin
                chk("rnd_order_pc", instr_pc, exp_pc);
                chk("rnd_order_instr", instr, rom[exp_pc]);
                ncons++;
                if (model_cnt < 65535) model_cnt++;
                if (r_be) exp_pc = r_br ? exp_pc + r_bo : r_bo;
                else exp_pc = exp_pc + 4'd1;
            end
            prev_stall = instr_valid & !r_rd;
            prev_redir = cons & r_be;
            prev_instr = instr;
            prev_ipc = instr_pc;
            @(posedge clk);
            #1;
        end
        chk("rnd_progress", (ncons > 500), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_fetch_seq.md
Name: prog_fetch_seq

Overview:
- Fetch sequencer for the picoMIPS program ROM.
- Owns the program counter and drives the ROM address.
- Captures the combinational ROM word into a one-entry output register and hands it to decode over a valid/ready handshake.
- Handles start, halt and absolute/relative branch redirects. Sits between the program ROM and the decode/execute stage.

Parameters:
- Psize, 4, ROM address width; program space is 2^Psize words.
- Isize, 17, instruction width (matches ROM word).
- RESET_ADDR, 0, PC value after reset and on start from IDLE.

Ports:
- clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- start  input  1  begin fetching (IDLE) or resume (HALT); ignored otherwise.
- halt_req  input  1  stop fetching after the output register drains.
- address  output  Psize  ROM address; always equals pc.
- I_mem  input  Isize  ROM data; combinational from address.
- instr  output  Isize  registered instruction to decode.
- instr_pc  output  Psize  address instr was fetched from.
- instr_valid  output  1  instr holds a valid word.
- instr_ready  input  1  decode accepts instr this cycle.
- branch_en  input  1  redirect; sampled only on a handshake cycle.
- branch_rel  input  1  1 = target is instr_pc + branch_off; 0 = target is branch_off.
- branch_off  input  Psize  branch target or offset, modulo 2^Psize.
- busy  output  1  high in RUN and DRAIN.

Behaviour:
- Reset (nReset low, asynchronous), values:
  - state=IDLE, pc=RESET_ADDR
  - instr=0, instr_pc=0, instr_valid=0, busy=0
- Handshake: consume = instr_valid & instr_ready. instr/instr_pc hold stable while instr_valid & !instr_ready.
- States:
  - IDLE:
    - No fetch; instr_valid=0.
    - start -> RUN with pc=RESET_ADDR.
  - RUN, checked in priority order each cycle:
    1. consume & branch_en: pc<=target (mod 2^Psize); instr_valid<=0. Exactly one bubble; the word at the old pc is discarded, never presented.
    2. Otherwise, if !instr_valid or consume: instr<=I_mem, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
    3. Otherwise (stall): pc, instr and instr_valid hold.
    - Independently, halt_req=1 -> DRAIN next cycle. The same-cycle fetch/branch still completes.
  - DRAIN:
    - No new fetch; pc holds.
    - When instr_valid=0 or consume: instr_valid<=0 and -> HALT.
    - A branch on the consuming handshake still updates pc.
  - HALT:
    - busy=0, pc frozen.
    - start -> RUN, resuming at the held pc.
- start in RUN/DRAIN, and halt_req in IDLE/HALT: ignored.
- pc wrap: 2^Psize-1 increments to 0. Relative target wraps identically.
- branch_en without consume: ignored.
- Latency:
  - start to first instr_valid: 2 cycles (state change, then fetch).
  - Steady state: 1 instruction/cycle with instr_ready=1.

Optional Feature:
- Macro: PROG_FETCH_RETCOUNT_EN.
- Defined:
  - Adds output ret_count [15:0], incremented on every consume.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by start from IDLE; not cleared by resume from HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, ROM[k]=k+100, instr_ready=1, pulse start -> instr_valid rises 2 cycles later. instr=100,101,...,115,100 with instr_pc 0..15,0 (wrap). No gaps.
- Backpressure: drop instr_ready for 3 cycles while instr=102 -> instr stays 102 and address stays 3. After release, next instr=103. No loss or duplicate.
- Absolute branch: consume instr_pc=5 with branch_en=1, branch_rel=0, branch_off=12 -> one cycle instr_valid=0, then instr_pc=12, instr=112. Word at 6 never valid.
- Relative wrap: consume instr_pc=14, branch_rel=1, branch_off=3 -> after one bubble, instr_pc=1, instr=101.
- Halt with stall: halt_req pulse while instr_valid=1, instr_ready=0 -> busy stays 1 and address frozen. On consume -> instr_valid=0, busy=0 next cycle. start -> resumes at the held address with no skip.
- Async reset mid-RUN at instr_pc=9 -> instr_valid, busy and address go to 0 without a clock edge. With PROG_FETCH_RETCOUNT_EN, ret_count=0. After 10 consumes, ret_count=10.
